// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier feeder: operand/product widths,
// queue depth, watchdog limit and the sequencer state encoding.
package booth_pkg;

   localparam int OPW        = 5;
   localparam int PW         = 10;
   localparam int FIFO_DEPTH = 4;
   localparam int WD_LIMIT   = 32;
   localparam int WDW        = 6;
   localparam int CNTW       = 3;
   localparam int PTRW       = 2;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } opPair_t;

   typedef enum logic [2:0] {
      IDLE,
      LDA,
      LDB,
      WAIT,
      HI,
      OUT
   } seqState_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Four-entry operand queue holding {a,b} pairs ahead of the multiplier.
// The head entry is visible combinationally; full/empty come from the count.
module booth_op_fifo
   import booth_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [2*OPW-1:0]  pushData,
   output logic [2*OPW-1:0]  popData,
   output logic [CNTW-1:0]   count,
   output logic              full,
   output logic              empty
);

   logic [2*OPW-1:0] mem [FIFO_DEPTH];
   logic [PTRW-1:0]  wrPtr;
   logic [PTRW-1:0]  rdPtr;
   logic             doPush;
   logic             doPop;

   assign full    = (count == CNTW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // Storage array; no reset needed since the count decides what is valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/booth_feeder.sv
// Feeds queued operand pairs into a two-beat Booth multiplier, reassembles the
// two result halves into a product, and guards the wait with a watchdog.
module booth_feeder
   import booth_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_a,
   input  logic [OPW-1:0] in_b,
   output logic           mul_rst,
   output logic           mul_start,
   output logic [OPW-1:0] mul_data,
   input  logic           mul_done,
   input  logic [OPW-1:0] mul_dout,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PW-1:0]  out_p,
   output logic           err
);

   seqState_t      state;
   seqState_t      nextState;
   opPair_t        head;
   logic [2*OPW-1:0] fifoHead;
   logic [CNTW-1:0] fifoCount;
   logic           fifoFull;
   logic           fifoEmpty;
   logic           fifoPush;
   logic           fifoPop;
   logic [WDW-1:0] wdCount;
   logic           mulRstPulse;
   logic [PW-1:0]  productReg;
   logic           errReg;
   logic           startC;
   logic [OPW-1:0] dataC;
   logic           popC;
   logic           wdExpire;
   logic           hiFail;
   logic           captureHi;
   logic           captureLo;

   assign head      = opPair_t'(fifoHead);
   assign in_ready  = !fifoFull && !rst;
   assign fifoPush  = in_valid && in_ready;
   assign fifoPop   = popC && !fifoEmpty;

   booth_op_fifo opFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifoPush),
      .pop      (fifoPop),
      .pushData ({in_a, in_b}),
      .popData  (fifoHead),
      .count    (fifoCount),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // Sequencer next-state and per-state strobes; the start is held off while a
   // watchdog reset pulse is still going out to the multiplier.
   always_comb begin
      nextState = state;
      startC    = 1'b0;
      dataC     = '0;
      popC      = 1'b0;
      wdExpire  = 1'b0;
      hiFail    = 1'b0;
      captureHi = 1'b0;
      captureLo = 1'b0;
      case (state)
         IDLE: begin
            if ((fifoCount != '0) && !mulRstPulse) begin
               startC    = 1'b1;
               nextState = LDA;
            end
         end
         LDA: begin
            dataC     = head.a;
            nextState = LDB;
         end
         LDB: begin
            dataC     = head.b;
            popC      = 1'b1;
            nextState = WAIT;
         end
         WAIT: begin
            if (mul_done) begin
               captureHi = 1'b1;
               nextState = HI;
            end else if (wdCount == WDW'(WD_LIMIT - 1)) begin
               wdExpire  = 1'b1;
               nextState = IDLE;
            end
         end
         HI: begin
            captureLo = 1'b1;
            if (mul_done) begin
               nextState = OUT;
            end else begin
               hiFail    = 1'b1;
               nextState = IDLE;
            end
         end
         OUT: begin
            if (out_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Watchdog counts WAIT cycles; it restarts as the pair leaves LDB.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdCount <= '0;
      end else if (state == LDB) begin
         wdCount <= '0;
      end else if ((state == WAIT) && !mul_done) begin
         wdCount <= wdCount + 1'b1;
      end
   end

   // Sticky error flag and the one-cycle multiplier reset after a timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         errReg      <= 1'b0;
         mulRstPulse <= 1'b0;
      end else begin
         mulRstPulse <= wdExpire;
         if (wdExpire || hiFail) begin
            errReg <= 1'b1;
         end
      end
   end

   // Product is the raw concatenation of the high beat then the low beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         productReg <= '0;
      end else begin
         if (captureHi) begin
            productReg[PW-1:OPW] <= mul_dout;
         end
         if (captureLo) begin
            productReg[OPW-1:0] <= mul_dout;
         end
      end
   end

   assign mul_start = startC && !rst;
   assign mul_data  = rst ? '0 : dataC;
   assign mul_rst   = rst || mulRstPulse;
   assign out_valid = (state == OUT) && !rst;
   assign out_p     = productReg;
   assign err       = errReg;

endmodule

// File: tb/tb_booth_feeder.sv
// Self-checking bench for booth_feeder with a behavioural two-beat Booth
// multiplier model whose done behaviour can be switched per test.
module tb_booth_feeder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_a;
   logic [4:0] in_b;
   logic       mul_rst;
   logic       mul_start;
   logic [4:0] mul_data;
   logic       mul_done;
   logic [4:0] mul_dout;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_p;
   logic       err;

   int total = 0;
   int bad   = 0;

   // Multiplier model controls and observations.
   int mode    = 0;
   int latency = 2;
   int phase   = 0;
   int cnt     = 0;
   int cyc     = 0;
   int wEntry  = 0;
   int rstCyc  = 0;
   int rstPulses = 0;
   int startViol = 0;
   int startCount = 0;
   bit rstSeen = 0;
   logic signed [4:0] ma;
   logic signed [4:0] mb;
   logic signed [9:0] prod;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic [9:0] expP;
   } vec_t;

   vec_t vecs [8];
   vec_t bb   [5];

   booth_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_rst   (mul_rst),
      .mul_start (mul_start),
      .mul_data  (mul_data),
      .mul_done  (mul_done),
      .mul_dout  (mul_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .err       (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: sees start, takes a then b on the next two
   // cycles, waits 'latency' cycles, then returns hi and lo halves.
   // mode 0 = normal, 1 = never done, 2 = single done beat.
   initial begin
      mul_done = 1'b0;
      mul_dout = '0;
      forever begin
         @(negedge clk);
         cyc++;
         mul_done = 1'b0;
         mul_dout = '0;
         if (mul_start && out_valid) startViol++;
         if (mul_start) startCount++;
         if (mul_rst) begin
            if (!rst) begin
               rstPulses++;
               if (!rstSeen) begin
                  rstSeen = 1'b1;
                  rstCyc  = cyc;
               end
            end
            phase = 0;
         end else begin
            case (phase)
               0: if (mul_start) phase = 1;
               1: begin ma = mul_data; phase = 2; end
               2: begin
                  mb = mul_data;
                  prod = ma * mb;
                  wEntry = cyc + 1;
                  cnt = latency;
                  phase = 3;
               end
               3: if (mode != 1) begin
                  if (cnt == 0) begin
                     mul_done = 1'b1;
                     mul_dout = prod[9:5];
                     phase = 4;
                  end else begin
                     cnt--;
                  end
               end
               4: begin
                  if (mode == 0) begin
                     mul_done = 1'b1;
                     mul_dout = prod[4:0];
                  end
                  phase = 0;
               end
               default: phase = 0;
            endcase
         end
      end
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one pair and hold it until it has been accepted.
   task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("push_ready", in_ready, 1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for a product to appear, with a cycle budget.
   task automatic waitOut(input string name);
      int guard = 0;
      while (!out_valid && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      checkOutput(name, out_valid, 1);
   endtask

   // Wait until the model has taken both operands and the pair sits in WAIT.
   task automatic waitInWait();
      int guard = 0;
      while (phase != 3 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("reach_wait", phase, 3);
      @(negedge clk);
   endtask

   // Main test sequence.
   initial begin
      int seen;
      int startsBefore;

      vecs[0] = '{a: 5'd7,  b: 5'h1D, expP: 10'h3EB};
      vecs[1] = '{a: 5'h10, b: 5'h10, expP: 10'h100};
      vecs[2] = '{a: 5'd0,  b: 5'h10, expP: 10'h000};
      vecs[3] = '{a: 5'd15, b: 5'd15, expP: 10'h0E1};
      vecs[4] = '{a: 5'h10, b: 5'd15, expP: 10'h310};
      vecs[5] = '{a: 5'd1,  b: 5'h1F, expP: 10'h3FF};
      vecs[6] = '{a: 5'h1F, b: 5'h1F, expP: 10'h001};
      vecs[7] = '{a: 5'd5,  b: 5'd6,  expP: 10'h01E};

      bb[0] = '{a: 5'd3,  b: 5'd4,  expP: 10'h00C};
      bb[1] = '{a: 5'h1E, b: 5'd5,  expP: 10'h3F6};
      bb[2] = '{a: 5'd9,  b: 5'h19, expP: 10'h3C1};
      bb[3] = '{a: 5'h18, b: 5'h18, expP: 10'h040};
      bb[4] = '{a: 5'd11, b: 5'd2,  expP: 10'h016};

      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_mul_rst", mul_rst, 1);
      checkOutput("rst_mul_start", mul_start, 0);
      checkOutput("rst_mul_data", mul_data, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_p", out_p, 0);
      checkOutput("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_mul_rst", mul_rst, 0);
      checkOutput("idle_in_ready", in_ready, 1);

      // Product held stable while the consumer stalls.
      applyStimulus(5'd7, 5'h1D);
      waitOut("hold_valid");
      checkOutput("hold_p0", out_p, 10'h3EB);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("hold_valid_k", out_valid, 1);
         checkOutput("hold_p_k", out_p, 10'h3EB);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("hold_release", out_valid, 0);

      // Table of single pairs through the normal path.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         waitOut("vec_valid");
         checkOutput($sformatf("vec%0d_p", i), out_p, vecs[i].expP);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_drop", i), out_valid, 0);
      end

      // Back-to-back pairs: queue fills behind a busy multiplier.
      latency = 10;
      fork
         begin
            applyStimulus(bb[0].a, bb[0].b);
            waitInWait();
            checkOutput("bb_ready_pre", in_ready, 1);
            for (int i = 1; i < 5; i++) begin
               if (i < 4) begin
                  in_valid = 1'b1;
                  in_a = bb[i].a;
                  in_b = bb[i].b;
                  @(negedge clk);
               end
            end
            in_valid = 1'b1;
            in_a = bb[4].a;
            in_b = bb[4].b;
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("bb_full_ready", in_ready, 0);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               waitOut("bb_valid");
               checkOutput($sformatf("bb%0d_p", i), out_p, bb[i].expP);
               @(negedge clk);
            end
         end
      join
      checkOutput("bb_start_viol", startViol, 0);
      checkOutput("bb_err", err, 0);

      // Watchdog: model never completes; the next queued pair still works.
      latency = 2;
      mode = 1;
      rstSeen = 1'b0;
      rstPulses = 0;
      applyStimulus(5'd2, 5'd3);
      applyStimulus(5'h1B, 5'd3);
      seen = 0;
      while (!rstSeen && seen < 200) begin
         @(negedge clk);
         seen++;
      end
      mode = 0;
      checkOutput("wd_pulse_seen", rstSeen, 1);
      checkOutput("wd_delay", rstCyc - wEntry, 32);
      checkOutput("wd_err", err, 1);
      checkOutput("wd_no_valid", out_valid, 0);
      waitOut("wd_next_valid");
      checkOutput("wd_next_p", out_p, 10'h3F1);
      checkOutput("wd_single_pulse", rstPulses, 1);
      checkOutput("wd_err_sticky", err, 1);
      @(negedge clk);

      // Reset during WAIT with three pairs queued.
      latency = 20;
      applyStimulus(5'd2, 5'd2);
      waitInWait();
      applyStimulus(5'd1, 5'd1);
      applyStimulus(5'd3, 5'd3);
      applyStimulus(5'd4, 5'd4);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_mul_rst", mul_rst, 1);
      checkOutput("mid_rst_in_ready", in_ready, 0);
      checkOutput("mid_rst_valid", out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", in_ready, 1);
      checkOutput("post_rst_err", err, 0);
      checkOutput("post_rst_p", out_p, 0);
      startsBefore = startCount;
      repeat (10) @(negedge clk);
      checkOutput("post_rst_no_start", startCount - startsBefore, 0);
      checkOutput("post_rst_no_valid", out_valid, 0);
      latency = 2;
      applyStimulus(5'd6, 5'h1B);
      waitOut("post_rst_valid");
      checkOutput("post_rst_prod", out_p, 10'h3E2);
      @(negedge clk);

      // Single done beat: error, no product.
      checkOutput("single_err_before", err, 0);
      mode = 2;
      applyStimulus(5'd4, 5'd4);
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("single_no_valid", seen, 0);
      checkOutput("single_err", err, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] time limit");
   end

endmodule
